// File: rtl/fcpu_support_peripherals.sv
// fcpu_support_peripherals: dual-port RAM, three-output clock divider and two button debouncers
module fcpu_debounce #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(N + 1);
  logic s1_q, s2_q, out_q, out_d, diff, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff  = s2_q != out_q;
    hit   = diff && cnt_q == CW'(N - 1);
    cnt_d = !strobe ? cnt_q : (!diff || hit) ? '0 : cnt_q + 1'b1;
    out_d = (strobe && hit) ? s2_q : out_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = out_q;
endmodule

module fcpu_support_peripherals #(
  parameter int    ADDR_W      = 11,
  parameter string INIT_FILE   = "",
  parameter int    HALF_1K     = 25000,
  parameter int    HALF_100    = 250000,
  parameter int    HALF_CPU    = 12500000,
  parameter int    DEB_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        data_a,
  input  logic [7:0]        data_b,
  input  logic              we_a,
  input  logic              we_b,
  output logic [7:0]        q_a,
  output logic [7:0]        q_b,
  input  logic              but1_in,
  input  logic              but2_in,
  output logic              but1_out,
  output logic              but2_out,
  output logic              clk_1khz,
  output logic              clk_100hz,
  output logic              clk_cpu
);
  localparam int W1 = HALF_1K  > 1 ? $clog2(HALF_1K)  : 1;
  localparam int W2 = HALF_100 > 1 ? $clog2(HALF_100) : 1;
  localparam int W3 = HALF_CPU > 1 ? $clog2(HALF_CPU) : 1;
  logic [7:0] mem [2**ADDR_W];
  logic [7:0] qa_q, qa_d, qb_q, qb_d;
  logic [W1-1:0] c1_q, c1_d;
  logic [W2-1:0] c2_q, c2_d;
  logic [W3-1:0] c3_q, c3_d;
  logic o1_q, o1_d, o2_q, o2_d, o3_q, o3_d, w1, w2, w3, strobe;
  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
    if (we_a) mem[addr_a] <= data_a;
  end
  always_comb begin
    qa_d   = mem[addr_a];
    qb_d   = mem[addr_b];
    w1     = c1_q == W1'(HALF_1K - 1);
    w2     = c2_q == W2'(HALF_100 - 1);
    w3     = c3_q == W3'(HALF_CPU - 1);
    c1_d   = w1 ? '0 : c1_q + 1'b1;
    c2_d   = w2 ? '0 : c2_q + 1'b1;
    c3_d   = w3 ? '0 : c3_q + 1'b1;
    o1_d   = o1_q ^ w1;
    o2_d   = o2_q ^ w2;
    o3_d   = o3_q ^ w3;
    strobe = w1 && o1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qa_q <= '0;
      qb_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
      o1_q <= 1'b0;
      o2_q <= 1'b0;
      o3_q <= 1'b0;
    end else begin
      qa_q <= qa_d;
      qb_q <= qb_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      c3_q <= c3_d;
      o1_q <= o1_d;
      o2_q <= o2_d;
      o3_q <= o3_d;
    end
  end
  fcpu_debounce #(.N(DEB_SAMPLES)) u_deb1 (.clk(clk), .rst(rst), .strobe(strobe), .raw(but1_in), .level(but1_out));
  fcpu_debounce #(.N(DEB_SAMPLES)) u_deb2 (.clk(clk), .rst(rst), .strobe(strobe), .raw(but2_in), .level(but2_out));
  assign q_a       = qa_q;
  assign q_b       = qb_q;
  assign clk_1khz  = o1_q;
  assign clk_100hz = o2_q;
  assign clk_cpu   = o3_q;
endmodule

// File: tb/tb_fcpu_support_peripherals.sv
// tb_fcpu_support_peripherals: directed plus random checks against a cycle-count reference model
module tb_fcpu_support_peripherals;
  localparam int H1 = 2, H100 = 5, HC = 10, DS = 3, AW = 11;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [7:0] data_a = '0, data_b = '0, q_a, q_b;
  logic we_a = 1'b0, we_b = 1'b0, but1_in = 1'b0, but2_in = 1'b0;
  logic but1_out, but2_out, clk_1khz, clk_100hz, clk_cpu;
  int checks = 0, errors = 0;
  int n;
  logic [7:0] mm [2**AW];
  bit known [2**AW];
  logic [7:0] eqa, eqb;
  bit qa_ok, qb_ok;
  bit dout [2];
  int dcnt [2];
  bit pipe0 [$], pipe1 [$];

  fcpu_support_peripherals #(
    .ADDR_W(AW), .INIT_FILE(""), .HALF_1K(H1), .HALF_100(H100), .HALF_CPU(HC), .DEB_SAMPLES(DS)
  ) dut (
    .clk(clk), .rst(rst), .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b), .but1_in(but1_in), .but2_in(but2_in),
    .but1_out(but1_out), .but2_out(but2_out), .clk_1khz(clk_1khz), .clk_100hz(clk_100hz), .clk_cpu(clk_cpu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    eqa = 8'h00;
    eqb = 8'h00;
    qa_ok = 1'b1;
    qb_ok = 1'b1;
    dout[0] = 1'b0;
    dout[1] = 1'b0;
    dcnt[0] = 0;
    dcnt[1] = 0;
    pipe0 = '{1'b0, 1'b0};
    pipe1 = '{1'b0, 1'b0};
  endtask

  task automatic deb(input int i, input bit s);
    if (s == dout[i]) dcnt[i] = 0;
    else begin
      dcnt[i]++;
      if (dcnt[i] == DS) begin
        dout[i] = s;
        dcnt[i] = 0;
      end
    end
  endtask

  task automatic tick();
    bit s0, s1;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      n++;
      s0 = pipe0.pop_front();
      s1 = pipe1.pop_front();
      pipe0.push_back(but1_in);
      pipe1.push_back(but2_in);
      if (n % (2 * H1) == 0) begin
        deb(0, s0);
        deb(1, s1);
      end
      eqa = mm[addr_a];
      qa_ok = known[addr_a];
      eqb = mm[addr_b];
      qb_ok = known[addr_b];
    end
    if (we_b) begin mm[addr_b] = data_b; known[addr_b] = 1'b1; end
    if (we_a) begin mm[addr_a] = data_a; known[addr_a] = 1'b1; end
    #1;
    chk("clk_1khz", clk_1khz, (n / H1) % 2);
    chk("clk_100hz", clk_100hz, (n / H100) % 2);
    chk("clk_cpu", clk_cpu, (n / HC) % 2);
    chk("but1_out", but1_out, dout[0]);
    chk("but2_out", but2_out, dout[1]);
    if (qa_ok) chk("q_a", q_a, eqa);
    if (qb_ok) chk("q_b", q_b, eqb);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) known[i] = 1'b0;
    model_reset();
    ticks(3);
    chk("reset_q_a", q_a, 8'h00);
    chk("reset_clk_1khz", clk_1khz, 0);
    rst = 1'b0;
    addr_a = 11'h003; data_a = 8'h3C; we_a = 1'b1;
    tick();
    data_a = 8'hA5;
    tick();
    chk("read_first_a", q_a, 8'h3C);
    we_a = 1'b0; addr_b = 11'h003;
    tick();
    chk("cross_read_b", q_b, 8'hA5);
    addr_a = 11'h7FF; addr_b = 11'h7FF; data_a = 8'h11; data_b = 8'h22; we_a = 1'b1; we_b = 1'b1;
    tick();
    we_a = 1'b0; we_b = 1'b0;
    tick();
    chk("collision_a", q_a, 8'h11);
    chk("collision_b", q_b, 8'h11);
    ticks(20);
    but1_in = 1'b1;
    ticks(24);
    chk("press_but1", but1_out, 1);
    but1_in = 1'b0;
    ticks(24);
    chk("release_but1", but1_out, 0);
    while (n % (2 * H1) != 1) tick();
    but2_in = 1'b1;
    ticks(8);
    but2_in = 1'b0;
    ticks(16);
    chk("glitch_but2", but2_out, 0);
    for (int i = 0; i < 500; i++) begin
      addr_a = AW'($urandom_range(8, 15));
      addr_b = AW'($urandom_range(8, 15));
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      we_a = 1'($urandom);
      we_b = 1'($urandom);
      if ($urandom_range(0, 15) == 0) but1_in = ~but1_in;
      if ($urandom_range(0, 15) == 0) but2_in = ~but2_in;
      tick();
    end
    we_a = 1'b0; we_b = 1'b0; but1_in = 1'b1; but2_in = 1'b0;
    ticks(25);
    chk("pre_rst_but1", but1_out, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_q_a", q_a, 8'h00);
    chk("async_q_b", q_b, 8'h00);
    chk("async_but1", but1_out, 0);
    chk("async_1khz", clk_1khz, 0);
    chk("async_100hz", clk_100hz, 0);
    chk("async_cpu", clk_cpu, 0);
    ticks(3);
    rst = 1'b0;
    addr_a = 11'h003;
    tick();
    chk("retain_003", q_a, 8'hA5);
    ticks(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
